// File: rtl/sap_control_unit.sv
// sap_control_unit: SAP-1 style T-state sequencer with combinational control-word decode,
// halt state and retired-instruction counter.
module sap_control_unit (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  t_state,
    output logic        halted,
    output logic [7:0]  retired
);
    localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

    typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, HALT = 3'd5} state_t;

    state_t     state_q, state_d;
    logic [7:0] retired_q, retired_d;
    logic       last;

    // T4 always terminates so a mid-instruction opcode change can never strand the sequencer
    always_comb begin
        case (state_q)
            T1:      last = (opcode == 4'h0) || (opcode >= 4'h9 && opcode <= 4'hD);
            T2:      last = (opcode >= 4'h5 && opcode <= 4'h8) || (opcode == 4'hE);
            T3:      last = (opcode == 4'h1) || (opcode == 4'h4);
            T4:      last = 1'b1;
            default: last = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        if (step_en && state_q != HALT) begin
            if (state_q == T2 && opcode == 4'hF) begin
                state_d   = HALT;
                retired_d = retired_q + 8'd1;
            end else if (last) begin
                state_d   = T0;
                retired_d = retired_q + 8'd1;
            end else begin
                state_d = state_t'(state_q + 3'd1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= T0;
            retired_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        case (state_q)
            T0: ctrl = CO | MI;
            T1: ctrl = RO | II | CE;
            T2: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4: ctrl = IO | MI;
                    4'h5:    ctrl = IO | AI;
                    4'h6:    ctrl = IO | J;
                    4'h7:    ctrl = flag_c ? (IO | J) : 16'h0000;
                    4'h8:    ctrl = flag_z ? (IO | J) : 16'h0000;
                    4'hE:    ctrl = AO | OI;
                    4'hF:    ctrl = HLT;
                    default: ctrl = 16'h0000;
                endcase
            end
            T3: begin
                case (opcode)
                    4'h1:       ctrl = RO | AI;
                    4'h2, 4'h3: ctrl = RO | BI;
                    4'h4:       ctrl = AO | RI;
                    default:    ctrl = 16'h0000;
                endcase
            end
            T4: begin
                case (opcode)
                    4'h2:    ctrl = EO | AI | FI;
                    4'h3:    ctrl = EO | AI | FI | SU;
                    default: ctrl = 16'h0000;
                endcase
            end
            HALT:    ctrl = HLT;
            default: ctrl = 16'h0000;
        endcase
    end

    assign halted  = (state_q == HALT);
    assign t_state = halted ? 3'd0 : state_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_sap_control_unit.sv
// tb_sap_control_unit: directed vectors with hand-computed control words for sap_control_unit.
module tb_sap_control_unit;
    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        step_en  = 1'b0;
    logic [3:0]  opcode   = 4'h0;
    logic        flag_c   = 1'b0;
    logic        flag_z   = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  t_state;
    logic        halted;
    logic [7:0]  retired;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] exp_ret = 8'd0;

    sap_control_unit dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .step_en (step_en),
        .opcode  (opcode),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .ctrl    (ctrl),
        .t_state (t_state),
        .halted  (halted),
        .retired (retired)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Runs one instruction of n states from T0 and checks every T-state and the retire count
    task automatic run_op(input string tag, input logic [3:0] op, input int n,
                          input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        opcode  = op;
        step_en = 1'b1;
        chk({tag, "_c0"}, ctrl, 16'h4004);
        chk({tag, "_t0"}, 16'(t_state), 16'd0);
        tick();
        chk({tag, "_c1"}, ctrl, 16'h1408);
        chk({tag, "_t1"}, 16'(t_state), 16'd1);
        for (int i = 2; i < n; i++) begin
            tick();
            chk($sformatf("%s_c%0d", tag, i), ctrl, i == 2 ? e2 : i == 3 ? e3 : e4);
            chk($sformatf("%s_t%0d", tag, i), 16'(t_state), 16'(i));
        end
        tick();
        exp_ret = exp_ret + 8'd1;
        chk({tag, "_end_t"}, 16'(t_state), 16'd0);
        chk({tag, "_ret"}, 16'(retired), 16'(exp_ret));
    endtask

    logic [15:0] lda_exp [4] = '{16'h4004, 16'h1408, 16'h4800, 16'h1200};

    initial begin
        #3;
        chk("rst_ctrl", ctrl, 16'h4004);
        chk("rst_t", 16'(t_state), 16'd0);
        chk("rst_ret", 16'(retired), 16'd0);
        chk("rst_halt", 16'(halted), 16'd0);
        step_en = 1'b1;
        tick();
        chk("rst_hold_t", 16'(t_state), 16'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        run_op("add", 4'h2, 5, 16'h4800, 16'h1020, 16'h0281);
        run_op("sub", 4'h3, 5, 16'h4800, 16'h1020, 16'h02C1);
        run_op("lda", 4'h1, 4, 16'h4800, 16'h1200, 16'h0000);
        run_op("sta", 4'h4, 4, 16'h4800, 16'h2100, 16'h0000);
        run_op("ldi", 4'h5, 3, 16'h0A00, 16'h0000, 16'h0000);
        run_op("jmp", 4'h6, 3, 16'h0802, 16'h0000, 16'h0000);
        run_op("out", 4'hE, 3, 16'h0110, 16'h0000, 16'h0000);
        run_op("nop", 4'h0, 2, 16'h0000, 16'h0000, 16'h0000);
        flag_c = 1'b0; flag_z = 1'b1;
        run_op("jc0", 4'h7, 3, 16'h0000, 16'h0000, 16'h0000);
        run_op("jz1", 4'h8, 3, 16'h0802, 16'h0000, 16'h0000);
        flag_c = 1'b1; flag_z = 1'b0;
        run_op("jc1", 4'h7, 3, 16'h0802, 16'h0000, 16'h0000);
        run_op("jz0", 4'h8, 3, 16'h0000, 16'h0000, 16'h0000);
        flag_c = 1'b0;

        opcode = 4'h1;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                step_en = (k == 3);
                chk($sformatf("slow_c%0d_%0d", i, k), ctrl, lda_exp[i]);
                chk($sformatf("slow_t%0d_%0d", i, k), 16'(t_state), 16'(i));
                tick();
            end
        end
        exp_ret = exp_ret + 8'd1;
        chk("slow_end_t", 16'(t_state), 16'd0);
        chk("slow_ret", 16'(retired), 16'(exp_ret));

        opcode  = 4'h3;
        step_en = 1'b1;
        tick(); tick(); tick();
        chk("subrst_pre_c", ctrl, 16'h1020);
        chk("subrst_pre_t", 16'(t_state), 16'd3);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("subrst_t", 16'(t_state), 16'd0);
        chk("subrst_c", ctrl, 16'h4004);
        chk("subrst_ret", 16'(retired), 16'd0);
        exp_ret = 8'd0;
        RESET_N = 1'b1;
        run_op("subresume", 4'h3, 5, 16'h4800, 16'h1020, 16'h02C1);

        opcode = 4'hF;
        tick(); tick();
        chk("hlt_t2_c", ctrl, 16'h8000);
        chk("hlt_t2_h", 16'(halted), 16'd0);
        tick();
        exp_ret = exp_ret + 8'd1;
        chk("hlt_c", ctrl, 16'h8000);
        chk("hlt_h", 16'(halted), 16'd1);
        chk("hlt_t", 16'(t_state), 16'd0);
        chk("hlt_ret", 16'(retired), 16'(exp_ret));
        for (int i = 0; i < 100; i++) begin
            step_en = 1'b1;
            opcode  = 4'($urandom_range(0, 15));
            flag_c  = 1'($urandom_range(0, 1));
            flag_z  = 1'($urandom_range(0, 1));
            tick();
        end
        chk("hlt_stay_c", ctrl, 16'h8000);
        chk("hlt_stay_h", 16'(halted), 16'd1);
        chk("hlt_stay_t", 16'(t_state), 16'd0);
        chk("hlt_stay_ret", 16'(retired), 16'(exp_ret));
        #2;
        RESET_N = 1'b0;
        #1;
        chk("hltrst_h", 16'(halted), 16'd0);
        chk("hltrst_c", ctrl, 16'h4004);
        chk("hltrst_ret", 16'(retired), 16'd0);
        exp_ret = 8'd0;
        RESET_N = 1'b1;
        flag_c  = 1'b0;
        flag_z  = 1'b0;

        run_op("nopA", 4'hA, 2, 16'h0000, 16'h0000, 16'h0000);
        step_en = 1'b1;
        for (int i = 0; i < 255; i++) begin
            opcode = (i % 2 == 0) ? 4'h0 : 4'hC;
            tick(); tick();
        end
        chk("wrap_t", 16'(t_state), 16'd0);
        chk("wrap_ret", 16'(retired), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sap_control_unit.md
SAP_CONTROL_UNIT -- requirements
Module: sap_control_unit

Interface
REQ-001 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port step_en, input, 1 bit: datapath step strobe; the T-state advances only on edges where it is 1.
REQ-004 SHALL have port opcode, input, 4 bits: instruction register upper nibble, valid from T2 onward.
REQ-005 SHALL have port flag_c, input, 1 bit: registered carry flag from the datapath.
REQ-006 SHALL have port flag_z, input, 1 bit: registered zero flag from the datapath.
REQ-007 SHALL have port ctrl, output, 16 bits: control word, bit order [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
REQ-008 SHALL have port t_state, output, 3 bits: current T-state, 0..4, for LEDs.
REQ-009 SHALL have port halted, output, 1 bit: HALTED state indicator.
REQ-010 SHALL have port retired, output, 8 bits: count of completed instructions.

Function
REQ-011 SHALL use states T0..T4 plus HALTED; ctrl SHALL be a combinational decode of state, opcode, flag_c and flag_z, stable for the whole state.
REQ-012 SHALL, with step_en=0, hold state and retired unchanged.
REQ-013 SHALL drive T0 as CO|MI and T1 as RO|II|CE for every opcode.
REQ-014 SHALL decode T2..T4 by opcode: 0000 NOP (no T2); 0001 LDA T2 IO|MI, T3 RO|AI; 0010 ADD T2 IO|MI, T3 RO|BI, T4 EO|AI|FI; 0011 SUB as ADD with SU added in T4; 0100 STA T2 IO|MI, T3 AO|RI; 0101 LDI T2 IO|AI; 0110 JMP T2 IO|J; 0111 JC T2 IO|J if flag_c else 0; 1000 JZ T2 IO|J if flag_z else 0; 1110 OUT T2 AO|OI; 1111 HLT T2 HLT.
REQ-015 SHALL treat opcodes 1001..1101 exactly as NOP.
REQ-016 SHALL end each instruction at its last listed state; the next stepped edge SHALL go to T0 and increment retired. Last states: NOP T1; LDI/JMP/JC/JZ/OUT T2; LDA/STA T3; ADD/SUB T4.
REQ-017 SHALL end untaken JC/JZ at T2 with ctrl=0, same length as taken.
REQ-018 SHALL, on a stepped edge in T2 with opcode 1111, enter HALTED and increment retired.
REQ-019 SHALL, in HALTED, drive ctrl=16'h8000, halted=1 and t_state=0, ignoring step_en and all inputs until reset.
REQ-020 SHALL wrap retired from 255 to 0.
REQ-021 SHALL sample flag_c/flag_z in T2 only through the combinational ctrl decode; the controller holds no flag copy.

Reset
REQ-022 SHALL, on RESET_N=0, immediately and regardless of clock enter T0 with retired=0 and halted=0; ctrl=16'h4004 (CO|MI), including mid-instruction or from HALTED.
REQ-023 SHALL resume stepping on the first stepped edge after RESET_N returns to 1.

Verification
REQ-024 SHALL verify: reset, step_en=1, opcode=0010 -> ctrl sequence 4004, 1408, 4800, 1020, 0281; t_state 0,1,2,3,4,0; retired=1.
REQ-025 SHALL verify: JC opcode=0111 with flag_c=0 -> T2 ctrl=0000 then T0; with flag_c=1 -> T2 ctrl=0802.
REQ-026 SHALL verify: opcode=1111 after T1 -> HALTED; ctrl=8000, halted=1, 100 further step_en edges leave state and retired unchanged.
REQ-027 SHALL verify: 256 NOPs (2 steps each) -> retired wraps to 0; opcode=1010 behaves as NOP.
REQ-028 SHALL verify: step_en toggled 1-in-4 during LDA -> each state held 4 clocks, ctrl unchanged within a state.
REQ-029 SHALL verify: RESET_N pulsed low in T3 of SUB, between clock edges -> t_state=0, ctrl=4004, retired=0 before the next clock edge.
